ddr3_iod_dly_ctrl: RTL and testbench

//  Round-robin scheduler for the dynamic delay lines of the DDR3 CA/CTRL IODs (CAS_N, RAS_N, WE_N, ...).

---
 rtl/ddr3_iod_dly_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ddr3_iod_dly_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_iod_dly_ctrl.sv
// ddr3_iod_dly_ctrl
//   Round-robin scheduler for the dynamic delay lines of the DDR3 CA/CTRL IODs.
//   Training logic posts per-lane inc/dec/load requests. One lane is served
//   at a time. The block drives spaced MOVE/LOAD pulses and tracks the tap
//   position of each lane. An op stops with ERR when the IOD reports
//   out-of-range, or when a further step would saturate the tap counter.
// Ports
//   FAB_CLK, SYNC_RST        clock, synchronous active-high reset
//   REQ_VALID/REQ_READY      per-lane handshake; READY is one-hot while arbitrating
//   REQ_OP, REQ_COUNT        per-lane op (00 inc, 01 dec, 10 load, 11 nop) and step count
//   DONE, ERR                per-lane completion pulse and abort flag
//   DELAY_LINE_*             to/from the PF_IOD delay-line controls
//   TAP_POS                  tracked tap per lane
//   BUSY                     an op is in progress (not idle, not arbitrating)
module ddr3_iod_dly_ctrl #(
   parameter int NUM_LANES = 4,
   parameter int TAP_W     = 8,
   parameter int MOVE_GAP  = 4,
   parameter int INIT_TAP  = 1
) (
   input  logic                         FAB_CLK,
   input  logic                         SYNC_RST,
   input  logic [NUM_LANES-1:0]         REQ_VALID,
   output logic [NUM_LANES-1:0]         REQ_READY,
   input  logic [2*NUM_LANES-1:0]       REQ_OP,
   input  logic [TAP_W*NUM_LANES-1:0]   REQ_COUNT,
   output logic [NUM_LANES-1:0]         DONE,
   output logic [NUM_LANES-1:0]         ERR,
   output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
   output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
   input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
   output logic [TAP_W*NUM_LANES-1:0]   TAP_POS,
   output logic                         BUSY
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int GAP_W  = $clog2(MOVE_GAP + 1);
   localparam logic [TAP_W-1:0] MAX_TAP  = {TAP_W{1'b1}};
   localparam logic [TAP_W-1:0] INIT_VAL = TAP_W'(INIT_TAP);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   logic [2:0]        state_reg;
   logic [LANE_W-1:0] ptr_reg;
   logic [LANE_W-1:0] lane_reg;
   logic [1:0]        op_reg;
   logic [TAP_W-1:0]  remaining_reg;
   logic [GAP_W-1:0]  gap_reg;
   logic              err_reg;
   logic [TAP_W-1:0]  tap_reg [NUM_LANES];
   logic [NUM_LANES-1:0] dir_reg;

   logic [1:0]        req_op_arr    [NUM_LANES];
   logic [TAP_W-1:0]  req_count_arr [NUM_LANES];

   logic              grant_found;
   logic [LANE_W-1:0] grant_lane;
   logic [1:0]        grant_op;
   logic [TAP_W-1:0]  grant_count;
   logic [TAP_W-1:0]  cur_tap;
   logic [TAP_W-1:0]  step_tap;
   logic [TAP_W-1:0]  remaining_dec;

   // True when one more step of this op from this tap would leave the range.
   function automatic logic is_sat(input logic [1:0] op, input logic [TAP_W-1:0] tap);
      return ((op == OP_INC) && (tap == MAX_TAP)) || ((op == OP_DEC) && (tap == '0));
   endfunction

   // Per-lane unpacking of the request buses and per-lane output decode.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign req_op_arr[gi]    = REQ_OP[2*gi +: 2];
         assign req_count_arr[gi] = REQ_COUNT[TAP_W*gi +: TAP_W];

         assign REQ_READY[gi]       = (state_reg == S_ARB) && grant_found && (grant_lane == LANE_W'(gi));
         assign DELAY_LINE_MOVE[gi] = (state_reg == S_PULSE) && (lane_reg == LANE_W'(gi)) && (op_reg != OP_LOAD);
         assign DELAY_LINE_LOAD[gi] = (state_reg == S_PULSE) && (lane_reg == LANE_W'(gi)) && (op_reg == OP_LOAD);
         assign DONE[gi]            = (state_reg == S_FIN) && (lane_reg == LANE_W'(gi));
         assign ERR[gi]             = (state_reg == S_FIN) && (lane_reg == LANE_W'(gi)) && err_reg;
         assign DELAY_LINE_DIRECTION[gi]   = dir_reg[gi];
         assign TAP_POS[TAP_W*gi +: TAP_W] = tap_reg[gi];
      end
   endgenerate

   assign BUSY = (state_reg != S_IDLE) && (state_reg != S_ARB);

   // Round-robin search: first valid lane at or after the pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_lane  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!grant_found && REQ_VALID[(int'(ptr_reg) + k) % NUM_LANES]) begin
            grant_found = 1'b1;
            grant_lane  = LANE_W'((int'(ptr_reg) + k) % NUM_LANES);
         end
      end
   end

   assign grant_op      = req_op_arr[grant_lane];
   assign grant_count   = req_count_arr[grant_lane];
   assign cur_tap       = tap_reg[lane_reg];
   assign remaining_dec = remaining_reg - 1'b1;

   always_comb begin
      step_tap = INIT_VAL;
      if (op_reg == OP_INC) begin
         step_tap = cur_tap + 1'b1;
      end else if (op_reg == OP_DEC) begin
         step_tap = cur_tap - 1'b1;
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state_reg     <= S_IDLE;
         ptr_reg       <= '0;
         lane_reg      <= '0;
         op_reg        <= OP_NOP;
         remaining_reg <= '0;
         gap_reg       <= '0;
         err_reg       <= 1'b0;
         dir_reg       <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            tap_reg[i] <= INIT_VAL;
         end
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (|REQ_VALID) begin
                  state_reg <= S_ARB;
               end
            end
            S_ARB: begin
               err_reg <= 1'b0;
               if (!grant_found) begin
                  state_reg <= S_IDLE;
               end else begin
                  lane_reg <= grant_lane;
                  op_reg   <= grant_op;
                  ptr_reg  <= (grant_lane == LANE_W'(NUM_LANES - 1)) ? '0 : grant_lane + 1'b1;
                  // A load is a single step regardless of the requested count.
                  remaining_reg <= (grant_op == OP_LOAD) ? TAP_W'(1) : grant_count;
                  if ((grant_op == OP_NOP) || ((grant_op != OP_LOAD) && (grant_count == '0))) begin
                     state_reg <= S_FIN;
                  end else begin
                     state_reg <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               dir_reg[lane_reg] <= (op_reg == OP_INC);
               if (is_sat(op_reg, cur_tap)) begin
                  err_reg   <= 1'b1;
                  state_reg <= S_FIN;
               end else begin
                  state_reg <= S_PULSE;
               end
            end
            S_PULSE: begin
               gap_reg   <= GAP_W'(MOVE_GAP - 1);
               state_reg <= S_GAP;
            end
            S_GAP: begin
               if (gap_reg != '0) begin
                  gap_reg <= gap_reg - 1'b1;
               end else if (DELAY_LINE_OUT_OF_RANGE[lane_reg]) begin
                  // IOD rejected the step: the tap did not move.
                  err_reg   <= 1'b1;
                  state_reg <= S_FIN;
               end else begin
                  tap_reg[lane_reg] <= step_tap;
                  remaining_reg     <= remaining_dec;
                  if (remaining_dec == '0) begin
                     state_reg <= S_FIN;
                  end else if (is_sat(op_reg, step_tap)) begin
                     err_reg   <= 1'b1;
                     state_reg <= S_FIN;
                  end else begin
                     state_reg <= S_PULSE;
                  end
               end
            end
            S_FIN: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// Testbench for ddr3_iod_dly_ctrl: directed scenarios plus randomized ops,
// each compared against a step-by-step reference model of the delay line.
module tb_ddr3_iod_dly_ctrl;

   localparam int NL   = 4;
   localparam int TW   = 8;
   localparam int GAP  = 4;
   localparam int INIT = 1;
   localparam int MAXT = 255;
   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   logic              fab_clk = 1'b0;
   logic              sync_rst;
   logic [NL-1:0]     req_valid;
   logic [NL-1:0]     req_ready;
   logic [2*NL-1:0]   req_op;
   logic [TW*NL-1:0]  req_count;
   logic [NL-1:0]     done;
   logic [NL-1:0]     err;
   logic [NL-1:0]     dl_move;
   logic [NL-1:0]     dl_dir;
   logic [NL-1:0]     dl_load;
   logic [NL-1:0]     dl_oor;
   logic [TW*NL-1:0]  tap_pos;
   logic              busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int model_tap [NL];

   ddr3_iod_dly_ctrl #(
      .NUM_LANES(NL), .TAP_W(TW), .MOVE_GAP(GAP), .INIT_TAP(INIT)
   ) dut (
      .FAB_CLK(fab_clk),
      .SYNC_RST(sync_rst),
      .REQ_VALID(req_valid),
      .REQ_READY(req_ready),
      .REQ_OP(req_op),
      .REQ_COUNT(req_count),
      .DONE(done),
      .ERR(err),
      .DELAY_LINE_MOVE(dl_move),
      .DELAY_LINE_DIRECTION(dl_dir),
      .DELAY_LINE_LOAD(dl_load),
      .DELAY_LINE_OUT_OF_RANGE(dl_oor),
      .TAP_POS(tap_pos),
      .BUSY(busy)
   );

   always #5 fab_clk = ~fab_clk;
   always @(posedge fab_clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int tap_of(input int l);
      return int'(tap_pos[l*TW +: TW]);
   endfunction

   // Reference model: walk the op one step at a time over the tap range.
   // done is the DONE cycle relative to the grant cycle.
   function automatic void model(input logic [1:0] op, input int cnt, input int oor_step,
                                 input int start, output int pulses, output int done_at,
                                 output bit e, output int tap, output bit dir_set);
      int bound;
      pulses = 0; e = 1'b0; tap = start; dir_set = 1'b0; done_at = 1;
      if (op == OP_NOP || (op != OP_LOAD && cnt == 0)) return;
      dir_set = 1'b1;
      if (op == OP_LOAD) begin
         pulses = 1;
         if (oor_step == 1) e = 1'b1;
         else tap = INIT;
         done_at = 2 + (GAP + 1);
         return;
      end
      bound = (op == OP_INC) ? MAXT : 0;
      if (tap == bound) begin
         e = 1'b1;
         done_at = 2;
         return;
      end
      for (int s = 1; s <= cnt; s++) begin
         pulses = s;
         if (oor_step == s) begin
            e = 1'b1;
            break;
         end
         tap = (op == OP_INC) ? tap + 1 : tap - 1;
         if (s < cnt && tap == bound) begin
            e = 1'b1;
            break;
         end
      end
      done_at = 2 + pulses * (GAP + 1);
   endfunction

   task automatic run_op(input string name, input int lane, input logic [1:0] op,
                         input int cnt, input int oor_step);
      int exp_pulses, exp_done, exp_tap;
      bit exp_err, exp_dir_set;
      int pulses, done_rel, t0;
      bit err_seen, timing_bad, other_bad, kind_bad, got_ready;
      model(op, cnt, oor_step, model_tap[lane], exp_pulses, exp_done, exp_err, exp_tap, exp_dir_set);
      @(negedge fab_clk);
      req_op[2*lane +: 2]     = op;
      req_count[TW*lane +: TW] = TW'(cnt);
      req_valid[lane]         = 1'b1;
      got_ready = 1'b0;
      for (int w = 0; w < 20; w++) begin
         if (req_ready != '0) begin
            got_ready = 1'b1;
            break;
         end
         @(negedge fab_clk);
      end
      tests_run++;
      if (req_ready !== (NL'(1) << lane)) begin
         tests_failed++;
         $display("FAIL %s_grant: ready=%b required=%b", name, req_ready, NL'(1) << lane);
      end
      if (!got_ready) begin
         req_valid[lane] = 1'b0;
         return;
      end
      t0 = cyc;
      @(posedge fab_clk);
      #1 req_valid[lane] = 1'b0;
      pulses = 0; done_rel = -1; err_seen = 1'b0;
      timing_bad = 1'b0; other_bad = 1'b0; kind_bad = 1'b0;
      for (int c = 0; c < exp_done + 10; c++) begin
         @(negedge fab_clk);
         if (((dl_move | dl_load) & ~(NL'(1) << lane)) != '0) other_bad = 1'b1;
         if (dl_move[lane] || dl_load[lane]) begin
            if (cyc - t0 != 2 + pulses * (GAP + 1)) timing_bad = 1'b1;
            if (dl_load[lane] != (op == OP_LOAD)) kind_bad = 1'b1;
            pulses++;
            dl_oor[lane] = (pulses == oor_step);
         end
         if (done[lane]) begin
            done_rel = cyc - t0;
            err_seen = err[lane];
            break;
         end
      end
      dl_oor = '0;
      tests_run++;
      if (done_rel != exp_done) begin
         tests_failed++;
         $display("FAIL %s_done_time: got T+%0d required T+%0d", name, done_rel, exp_done);
      end
      tests_run++;
      if (err_seen != exp_err) begin
         tests_failed++;
         $display("FAIL %s_err: got %0b required %0b", name, err_seen, exp_err);
      end
      tests_run++;
      if (pulses != exp_pulses) begin
         tests_failed++;
         $display("FAIL %s_pulses: got %0d required %0d", name, pulses, exp_pulses);
      end
      tests_run++;
      if (timing_bad || kind_bad || other_bad) begin
         tests_failed++;
         $display("FAIL %s_pulse_shape: timing=%0b kind=%0b other_lane=%0b required all 0",
                  name, timing_bad, kind_bad, other_bad);
      end
      tests_run++;
      if (tap_of(lane) != exp_tap) begin
         tests_failed++;
         $display("FAIL %s_tap: got %0d required %0d", name, tap_of(lane), exp_tap);
      end
      if (exp_dir_set) begin
         tests_run++;
         if (dl_dir[lane] !== (op == OP_INC)) begin
            tests_failed++;
            $display("FAIL %s_dir: got %0b required %0b", name, dl_dir[lane], op == OP_INC);
         end
      end
      @(negedge fab_clk);
      tests_run++;
      if (done !== '0) begin
         tests_failed++;
         $display("FAIL %s_done_width: done=%b one cycle later, required 0", name, done);
      end
      model_tap[lane] = exp_tap;
      $display("[TB] %s lane=%0d op=%0d cnt=%0d oor_step=%0d done=T+%0d err=%0b pulses=%0d tap=%0d",
               name, lane, op, cnt, oor_step, done_rel, err_seen, pulses, tap_of(lane));
   endtask

   task automatic test_reset;
      sync_rst = 1'b1;
      req_valid = '0;
      dl_oor = '0;
      repeat (2) @(posedge fab_clk);
      @(negedge fab_clk);
      tests_run++;
      if ({req_ready, done, err, dl_move, dl_dir, dl_load, busy} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h required 0",
                  {req_ready, done, err, dl_move, dl_dir, dl_load, busy});
      end
      tests_run++;
      if (tap_pos !== {NL{TW'(INIT)}}) begin
         tests_failed++;
         $display("FAIL reset_tap: got %h required %h", tap_pos, {NL{TW'(INIT)}});
      end
      sync_rst = 1'b0;
      for (int l = 0; l < NL; l++) model_tap[l] = INIT;
      $display("[TB] reset applied, tap_pos=%h", tap_pos);
   endtask

   task automatic test_rr;
      int order[$];
      int expected[4];
      int g;
      bit re_req;
      expected = '{0, 1, 2, 0};
      @(negedge fab_clk);
      for (int l = 0; l < 3; l++) begin
         req_op[2*l +: 2] = OP_NOP;
         req_valid[l] = 1'b1;
      end
      re_req = 1'b0;
      for (int c = 0; c < 60 && order.size() < 4; c++) begin
         if (req_ready != '0) begin
            tests_run++;
            if ($countones(req_ready) != 1) begin
               tests_failed++;
               $display("FAIL rr_onehot: ready=%b required one-hot", req_ready);
            end
            g = 0;
            for (int l = 0; l < NL; l++) if (req_ready[l]) g = l;
            order.push_back(g);
            $display("[TB] rr grant lane=%0d at cycle %0d", g, cyc);
            @(posedge fab_clk);
            #1 req_valid[g] = 1'b0;
            if (!re_req && g == 0) begin
               req_valid[0] = 1'b1;
               re_req = 1'b1;
            end
         end
         @(negedge fab_clk);
      end
      req_valid = '0;
      tests_run++;
      if (order.size() != 4) begin
         tests_failed++;
         $display("FAIL rr_count: got %0d grants required 4", order.size());
      end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         tests_run++;
         if (order[i] != expected[i]) begin
            tests_failed++;
            $display("FAIL rr_order_%0d: got lane %0d required lane %0d", i, order[i], expected[i]);
         end
      end
      repeat (4) @(negedge fab_clk);
   endtask

   task automatic test_directed;
      run_op("inc_basic", 0, OP_INC, 3, 0);
      run_op("dec_prep", 1, OP_INC, 1, 0);
      run_op("dec_sat", 1, OP_DEC, 5, 0);
      run_op("oor", 2, OP_INC, 4, 2);
      run_op("load_prep", 3, OP_INC, 2, 0);
      run_op("load", 3, OP_LOAD, 9, 0);
      run_op("count_zero", 3, OP_INC, 0, 0);
      run_op("nop", 2, OP_NOP, 5, 0);
      run_op("load_oor", 2, OP_LOAD, 0, 1);
   endtask

   task automatic test_saturate_max;
      run_op("sat_max_run", 0, OP_INC, 255, 0);
      run_op("sat_max_start", 0, OP_INC, 1, 0);
      run_op("dec_from_max", 0, OP_DEC, 2, 0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 20; i++) begin
         int lane, cnt, oor_step;
         logic [1:0] op;
         lane = $urandom_range(0, NL - 1);
         op   = 2'($urandom_range(0, 3));
         cnt  = $urandom_range(0, 6);
         oor_step = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         run_op("rand", lane, op, cnt, oor_step);
      end
   endtask

   task automatic test_reset_mid;
      int pulses;
      bit got_ready;
      @(negedge fab_clk);
      req_op[2*1 +: 2] = OP_INC;
      req_count[TW*1 +: TW] = TW'(10);
      req_valid[1] = 1'b1;
      got_ready = 1'b0;
      for (int w = 0; w < 20; w++) begin
         if (req_ready[1]) begin
            got_ready = 1'b1;
            break;
         end
         @(negedge fab_clk);
      end
      @(posedge fab_clk);
      #1 req_valid[1] = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40 && pulses < 2; c++) begin
         @(negedge fab_clk);
         if (dl_move[1]) pulses++;
      end
      @(negedge fab_clk);
      @(negedge fab_clk);
      tests_run++;
      if (!got_ready || pulses != 2 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_setup: ready=%0b pulses=%0d busy=%0b required 1/2/1", got_ready, pulses, busy);
      end
      sync_rst = 1'b1;
      @(posedge fab_clk);
      #1 sync_rst = 1'b0;
      @(negedge fab_clk);
      tests_run++;
      if ({busy, dl_move, dl_load, done, err} !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_idle: busy/move/load/done/err=%h required 0", {busy, dl_move, dl_load, done, err});
      end
      tests_run++;
      if (tap_pos !== {NL{TW'(INIT)}}) begin
         tests_failed++;
         $display("FAIL rst_mid_tap: got %h required %h", tap_pos, {NL{TW'(INIT)}});
      end
      for (int l = 0; l < NL; l++) model_tap[l] = INIT;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge fab_clk);
         if ((done | dl_move) != '0) pulses++;
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("FAIL rst_mid_quiet: %0d cycles with done/move after reset, required 0", pulses);
      end
      $display("[TB] reset mid-op, tap_pos=%h", tap_pos);
      run_op("after_rst", 1, OP_INC, 1, 0);
   endtask

   initial begin
      sync_rst  = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_count = '0;
      dl_oor    = '0;
      test_reset;
      test_rr;
      test_directed;
      test_saturate_max;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
